synd_accum_banked: RTL and testbench
====================================

# synd_accum_banked

Parametrised, multi-bank Goppa syndrome accumulator for the decapsulation path. Consumes a valid/ready stream of (alpha, coef) pairs, where coef = g(alpha)^-2 is precomputed upstream, and accumulates S_j ^= coef·alpha^j for j = 0..2t-1 into a selectable syndrome bank. Successor to the fixed two-memory doubled-syndrome unit:
- Bank count is a parameter.
- Lane width is a parameter.
- Input uses a backpressured handshake.
- An optional on-chip bank comparator replaces the external re-encryption check.

## Interface
Parameters:
- m, 13, GF(2^m) element width
- t, 119, correction capability; each bank holds 2t words
- N, 20, parallel lanes (entries per block)
- BANKS, 2, number of syndrome banks; bank 0 is the comparison reference
- POLY, 14'h201B, field polynomial, m+1 bits including leading term

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears the selected bank and begins a run
- bank_sel  in  `CLOG2(BANKS)  target bank, sampled on start
- in_valid  in  1  entry valid
- in_ready  out  1  entry accepted when in_valid && in_ready
- in_alpha  in  m  evaluation point
- in_coef  in  m  g(alpha)^-2
- in_last  in  1  final entry of the run
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of run
- rd_en  in  1  external read enable
- rd_bank  in  `CLOG2(BANKS)  external read bank
- rd_addr  in  `CLOG2(2*t)  external read word
- rd_dout  out  m  registered read data
- cmp_equal  out  1  selected bank equals bank 0 (macro-dependent)

## Operation
- FSM states: IDLE, CLEAR, LOAD, ACC, CMP, DONE.
- IDLE: start moves to CLEAR and latches bank_sel. start is ignored in every state other than IDLE.
- CLEAR: writes zero to one word of the selected bank per cycle, addresses 0..2t-1, for 2t cycles, then moves to LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake stores alpha in lane register a[k] and coef in term register p[k], where k is the lane count.
  - Unfilled lanes hold p=0.
  - LOAD moves to ACC after the N-th handshake, or after any handshake with in_last=1.
- ACC: runs 2t cycles, with row counter j = 0..2t-1. Each cycle:
  - bank[j] <= bank[j] ^ XOR_k p[k]
  - p[k] <= p[k]·a[k]
  - At the end of ACC, lanes clear. If in_last was seen, go to CMP; otherwise go to LOAD.
- CMP (only when SYND_CMP_EN is defined): runs 2t cycles and compares word j of the selected bank with word j of bank 0. The result is then registered.
- DONE: done=1 for one cycle, then the FSM returns to IDLE.
- GF multiply is combinational: a polynomial product reduced by POLY. Additions are XOR.
- Banks are flop arrays, so a read-modify-write completes in a single cycle.

## Timing
- Reset values:
  - in_ready=0, busy=0, done=0, rd_dout=0, cmp_equal=0.
  - All bank words are 0.
  - FSM is in IDLE.
- Reset is honoured mid-run: the FSM returns to IDLE and all banks are zeroed.
- Run latency: start → done = 1 + 2t + Σ(L_b + 2t) + (SYND_CMP_EN ? 2t+1 : 0) + 1 cycles.
  - L_b is the number of LOAD cycles in block b, including stall cycles.
- in_ready falls in the cycle after the block-ending handshake. There are no lost or duplicated entries under arbitrary in_valid gaps.
- rd_dout has 1-cycle latency.
  - rd_dout holds its value when rd_en=0.
  - A read of a word being written in the same cycle returns the pre-write value.
  - Reads are legal in every state.
- rd_bank ≥ BANKS returns 0.
- bank_sel=0 is legal. With SYND_CMP_EN, bank_sel=0 yields cmp_equal=1.

## Configuration
- SYND_CMP_EN defined:
  - The CMP state is present.
  - cmp_equal updates one cycle before done and holds its value until the next accepted start, which clears it.
- SYND_CMP_EN undefined:
  - The CMP state and comparator are removed.
  - cmp_equal is tied to 0.
  - ACC with in_last moves directly to DONE.

## Test plan
Test parameters: m=4, POLY=5'h13, t=2, N=2, BANKS=2.
1. Single-entry run: start with bank 0, send (2,1,last) → bank0 = {1,2,4,8}; done 2+4+1+4+(5 if cmp) cycles after start.
2. Two entries in one block: send (2,1), (3,1,last) → bank0 = {0,1,1,7}.
3. Multi-block run with backpressure: send (2,1), (3,1), (4,1,last), with in_valid low for 3 cycles between entries → bank0 = {1,5,2,11}; in_ready is 0 during ACC; exactly 3 handshakes occur.
4. Comparator: run test 3 into bank 0, then the same run into bank 1 → cmp_equal=1. Repeat with the last entry (4,2) → cmp_equal=0. A start asserted while busy is ignored.
5. Reset: deassert rst_n during ACC → all outputs 0 and FSM in IDLE; rd_dout of every word reads 0 afterwards. A fresh run then matches test 1.

Source files
------------

// File: rtl/synd_accum_banked.sv
// Multi-bank Goppa syndrome accumulator: S_j ^= coef * alpha^j into a selected bank.
// Optional bank-vs-bank-0 comparator enabled by defining SYND_CMP_EN.
module synd_accum_banked #(
    parameter int unsigned m     = 13,
    parameter int unsigned t     = 119,
    parameter int unsigned N     = 20,
    parameter int unsigned BANKS = 2,
    parameter logic [m:0]  POLY  = 14'h201B,
    localparam int unsigned BW   = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int unsigned AW   = (2 * t > 1) ? $clog2(2 * t) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [BW-1:0] bank_sel,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [m-1:0]  in_alpha,
    input  logic [m-1:0]  in_coef,
    input  logic          in_last,
    output logic          busy,
    output logic          done,
    input  logic          rd_en,
    input  logic [BW-1:0] rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [m-1:0]  rd_dout,
    output logic          cmp_equal
);
    localparam int unsigned W   = 2 * t;
    localparam int unsigned CW  = $clog2(W + 1);
    localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW1 = BW + 1;
    localparam int unsigned AW1 = AW + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, ACC, CMP, DONE} state_t;

    state_t        state;
    logic [BW-1:0] sel;
    logic [CW-1:0] row;
    logic [KW-1:0] lane;
    logic          last_seen;
    logic [m-1:0]  a    [N];
    logic [m-1:0]  p    [N];
    logic [m-1:0]  bank [BANKS][W];
    logic [m-1:0]  p_sum;
    logic          sel_ok;
    logic          rd_ok;

    // Shift-and-add GF(2^m) multiply, reducing by POLY on each shift.
    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] x_in, input logic [m-1:0] y);
        logic [m-1:0] acc;
        logic [m-1:0] x;
        acc = '0;
        x   = x_in;
        for (int i = 0; i < int'(m); i++) begin
            if (y[i]) acc = acc ^ x;
            x = x[m-1] ? ((x << 1) ^ POLY[m-1:0]) : (x << 1);
        end
        return acc;
    endfunction

    always_comb begin
        p_sum = '0;
        for (int k = 0; k < int'(N); k++) p_sum = p_sum ^ p[k];
    end

    assign sel_ok = {1'b0, sel} < BW1'(BANKS);
    assign rd_ok  = ({1'b0, rd_bank} < BW1'(BANKS)) && ({1'b0, rd_addr} < AW1'(W));

`ifdef SYND_CMP_EN
    logic cmp_q;
    logic eq_acc;
    assign cmp_equal = cmp_q;
`else
    assign cmp_equal = 1'b0;
`endif

    // Control FSM, lane registers, bank array and read port share one register process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            row       <= '0;
            lane      <= '0;
            last_seen <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_dout   <= '0;
            for (int k = 0; k < int'(N); k++) begin
                a[k] <= '0;
                p[k] <= '0;
            end
            for (int b = 0; b < int'(BANKS); b++)
                for (int w = 0; w < int'(W); w++) bank[b][w] <= '0;
`ifdef SYND_CMP_EN
            cmp_q  <= 1'b0;
            eq_acc <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (rd_en) rd_dout <= rd_ok ? bank[rd_bank][rd_addr] : '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        sel       <= bank_sel;
                        row       <= '0;
                        lane      <= '0;
                        last_seen <= 1'b0;
                        busy      <= 1'b1;
                        for (int k = 0; k < int'(N); k++) begin
                            a[k] <= '0;
                            p[k] <= '0;
                        end
`ifdef SYND_CMP_EN
                        cmp_q <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    if (sel_ok) bank[sel][row[AW-1:0]] <= '0;
                    if (row == CW'(W - 1)) begin
                        row      <= '0;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        a[lane] <= in_alpha;
                        p[lane] <= in_coef;
                        if (in_last || lane == KW'(N - 1)) begin
                            in_ready  <= 1'b0;
                            state     <= ACC;
                            last_seen <= in_last;
                            lane      <= '0;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (sel_ok) bank[sel][row[AW-1:0]] <= bank[sel][row[AW-1:0]] ^ p_sum;
                    for (int k = 0; k < int'(N); k++) p[k] <= gf_mul(p[k], a[k]);
                    if (row == CW'(W - 1)) begin
                        row <= '0;
                        // Empty lanes must contribute zero to the next block.
                        for (int k = 0; k < int'(N); k++) begin
                            a[k] <= '0;
                            p[k] <= '0;
                        end
                        if (last_seen) begin
`ifdef SYND_CMP_EN
                            state  <= CMP;
                            eq_acc <= 1'b1;
`else
                            state  <= DONE;
`endif
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        row <= row + 1'b1;
                    end
                end
`ifdef SYND_CMP_EN
                CMP: begin
                    if (row == CW'(W)) begin
                        cmp_q <= eq_acc;
                        row   <= '0;
                        state <= DONE;
                    end else begin
                        if (!sel_ok || bank[sel][row[AW-1:0]] != bank[0][row[AW-1:0]])
                            eq_acc <= 1'b0;
                        row <= row + 1'b1;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_synd_accum_banked.sv
// Scoreboard bench for synd_accum_banked with m=4, t=2, N=2, BANKS=2, POLY=x^4+x+1.
module tb_synd_accum_banked;
    localparam int unsigned M = 4;
    localparam int unsigned T = 2;
    localparam int unsigned NL = 2;
    localparam int unsigned NB = 2;
`ifdef SYND_CMP_EN
    localparam int CMP_LAT = 5;
`else
    localparam int CMP_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [0:0]   bank_sel = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] in_alpha = '0;
    logic [M-1:0] in_coef = '0;
    logic         in_last = 1'b0;
    logic         busy;
    logic         done;
    logic         rd_en = 1'b0;
    logic [0:0]   rd_bank = '0;
    logic [1:0]   rd_addr = '0;
    logic [M-1:0] rd_dout;
    logic         cmp_equal;

    synd_accum_banked #(.m(M), .t(T), .N(NL), .BANKS(NB), .POLY(5'h13)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_alpha(in_alpha),
        .in_coef(in_coef), .in_last(in_last), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_dout(rd_dout), .cmp_equal(cmp_equal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   lat;
        logic cmp;
    } done_exp_t;

    done_exp_t    exp_done[$];
    logic [M-1:0] exp_rd[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           hs_cnt = 0;
    logic         rd_issued = 1'b0;
    logic         have_last = 1'b0;
    logic [M-1:0] last_rd = '0;
    logic [M-1:0] ea[3];
    logic [M-1:0] ec[3];

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic exp_cmp(input logic x);
`ifdef SYND_CMP_EN
        return x;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_issued <= rd_en;
    end

    // Monitor: pops expectations whenever the DUT presents read data or a done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_last = 1'b1;
            last_rd   = '0;
        end else begin
            if (in_valid && in_ready) hs_cnt++;
            if (rd_issued) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    last_rd   = exp_rd.pop_front();
                    have_last = 1'b1;
                    chk("rd_dout", int'(rd_dout), int'(last_rd));
                end
            end else if (have_last) begin
                chk("rd_hold", int'(rd_dout), int'(last_rd));
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    done_exp_t d;
                    d = exp_done.pop_front();
                    if (d.lat >= 0) chk("latency", cyc - start_cyc, d.lat);
                    chk("cmp_equal", int'(cmp_equal), int'(d.cmp));
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [M-1:0] al, input logic [M-1:0] co, input logic last,
                        input int gap, input logic ends_block, input logic poke_start);
        int   to;
        logic hs;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (poke_start && g == 1) begin
                start    = 1'b1;
                bank_sel = 1'b0;
            end
            tick();
            start = 1'b0;
        end
        in_alpha = al;
        in_coef  = co;
        in_last  = last;
        in_valid = 1'b1;
        to = 0;
        hs = 1'b0;
        while (!hs && to < 100) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            to++;
        end
        if (!hs) chk("handshake_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ends_block) begin
            @(negedge clk);
            chk("ready_drop", int'(in_ready), 0);
        end
    endtask

    task automatic run(input logic b, input int n, input int gap, input int lat, input logic cmp_x,
                       input logic poke, input logic prewrite, input logic [M-1:0] prev0);
        int to;
        tick();
        start     = 1'b1;
        bank_sel  = b;
        start_cyc = cyc;
        hs_cnt    = 0;
        exp_done.push_back('{lat, exp_cmp(cmp_x)});
        tick();
        start = 1'b0;
        chk("busy_run", int'(busy), 1);
        if (prewrite) begin
            // Word 0 is cleared on the same edge this read samples.
            rd_en = 1'b1; rd_bank = b; rd_addr = 2'd0;
            exp_rd.push_back(prev0);
            tick();
            exp_rd.push_back('0);
            tick();
            rd_en = 1'b0;
        end
        for (int i = 0; i < n; i++)
            send(ea[i], ec[i], i == n - 1, gap, (i == n - 1) || (i % int'(NL) == int'(NL) - 1),
                 poke && i == 1);
        to = 0;
        do begin
            @(negedge clk);
            to++;
        end while (!done && to < 200);
        if (!done) chk("done_timeout", 0, 1);
        chk("handshakes", hs_cnt, n);
    endtask

    task automatic readbank(input logic b, input logic [M-1:0] e0, input logic [M-1:0] e1,
                            input logic [M-1:0] e2, input logic [M-1:0] e3);
        logic [M-1:0] e[4];
        e = '{e0, e1, e2, e3};
        for (int j = 0; j < 4; j++) begin
            tick();
            rd_en = 1'b1; rd_bank = b; rd_addr = 2'(j);
            exp_rd.push_back(e[j]);
        end
        tick();
        rd_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_dout", int'(rd_dout), 0);
        chk("rst_cmp_equal", int'(cmp_equal), 0);
        tick();
        rst_n = 1'b1;

        // Single entry (2,1) -> {1,2,4,8}
        ea[0] = 4'd2; ec[0] = 4'd1;
        run(1'b0, 1, 0, 11 + CMP_LAT, 1'b1, 1'b0, 1'b0, '0);
        readbank(1'b0, 4'd1, 4'd2, 4'd4, 4'd8);

        // Two entries in one block -> {0,1,1,7}; also read-during-clear of word 0
        ea[0] = 4'd2; ec[0] = 4'd1; ea[1] = 4'd3; ec[1] = 4'd1;
        run(1'b0, 2, 0, 12 + CMP_LAT, 1'b1, 1'b0, 1'b1, 4'd1);
        readbank(1'b0, 4'd0, 4'd1, 4'd1, 4'd7);

        // Two blocks with gaps -> {1,5,2,11}
        ea[2] = 4'd4; ec[2] = 4'd1;
        run(1'b0, 3, 3, -1, 1'b1, 1'b0, 1'b0, '0);
        readbank(1'b0, 4'd1, 4'd5, 4'd2, 4'd11);

        // Same into bank 1 with a start pulse while busy -> equal
        run(1'b1, 3, 3, -1, 1'b1, 1'b1, 1'b0, '0);
        readbank(1'b1, 4'd1, 4'd5, 4'd2, 4'd11);

        // Last coef 2 -> {2,9,7,12}, differs from bank 0
        ec[2] = 4'd2;
        run(1'b1, 3, 3, -1, 1'b0, 1'b0, 1'b0, '0);
        readbank(1'b1, 4'd2, 4'd9, 4'd7, 4'd12);
        readbank(1'b0, 4'd1, 4'd5, 4'd2, 4'd11);
        repeat (10) tick();

        // Reset during ACC
        tick();
        start = 1'b1; bank_sel = 1'b0;
        tick();
        start = 1'b0;
        send(4'd2, 4'd1, 1'b1, 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        exp_done.delete();
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_rd_dout", int'(rd_dout), 0);
        chk("mid_rst_cmp_equal", int'(cmp_equal), 0);
        tick();
        rst_n = 1'b1;
        readbank(1'b0, '0, '0, '0, '0);
        readbank(1'b1, '0, '0, '0, '0);

        ea[0] = 4'd2; ec[0] = 4'd1;
        run(1'b0, 1, 0, 11 + CMP_LAT, 1'b1, 1'b0, 1'b0, '0);
        readbank(1'b0, 4'd1, 4'd2, 4'd4, 4'd8);

        repeat (5) tick();
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
